// File: rtl/osd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : osd_pkg
//  Description : Shared definitions for the OSD command scheduler. Holds the
//                command op encodings, the buffer geometry (8 lines of 256
//                bytes, 11-bit address) and the scheduler state and port
//                enumerations.
//  Revision    : 1.0 - initial release
// ============================================================================
package osd_pkg;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'd0,
        OP_CLEAR   = 2'd1,
        OP_ENABLE  = 2'd2,
        OP_DISABLE = 2'd3
    } osd_op_e;

    localparam int OSD_LINE_BYTES = 256;
    localparam int OSD_LINES      = 8;
    localparam int OSD_ADDR_W     = 11;
    localparam int OSD_LINE_W     = $clog2(OSD_LINES);
    localparam int OSD_BYTE_W     = $clog2(OSD_LINE_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } osd_state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } osd_port_e;

endpackage
`default_nettype wire

// File: rtl/osd_cmd_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter. On a tie the port that did not
//                win last time is chosen; a lone requester always wins. The
//                last-winner pointer moves only when advance is asserted with
//                at least one request present.
//  Ports       : clk, rst_n      - clock, asynchronous active-low reset
//                req_a, req_b    - requests
//                advance         - commit the current winner to the pointer
//                winner          - selected port (valid when valid = 1)
//                valid           - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import osd_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      req_a,
    input  logic      req_b,
    input  logic      advance,
    output osd_port_e winner,
    output logic      valid
);

    osd_port_e r_last;

    assign valid = req_a | req_b;

    always_comb begin
        winner = PORT_A;
        if (req_a && req_b) begin
            winner = (r_last == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            winner = PORT_B;
        end
    end

    // Reset points at B so that A takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= PORT_B;
        end else if (advance && valid) begin
            r_last <= winner;
        end
    end

endmodule
`default_nettype wire

// File: rtl/osd_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : osd_cmd_arbiter
//  Description : Schedules commands from two requesters (A: SPI decoder,
//                B: core-local messages) onto the single OSD buffer write
//                port and the OSD enable flag. Round-robin arbitration in
//                IDLE; WRITE streams up to 256 payload bytes into one line,
//                CLEAR fills one line with CLEAR_VALUE, ENABLE/DISABLE act
//                on the grant edge.
//  Ports       : clk_pix, reset_n           - clock, async active-low reset
//                {a,b}_req/_op/_line/_gnt   - command request / grant pulse
//                {a,b}_dat/_dat_valid/_ready- WRITE payload handshake
//                buf_we/buf_addr/buf_wdata  - registered buffer write port
//                osd_enable                 - display enable flag
//                busy                       - scheduler not in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module osd_cmd_arbiter
    import osd_pkg::*;
#(
    parameter logic [7:0] CLEAR_VALUE  = 8'h00,
    parameter logic       RESET_ENABLE = 1'b0
) (
    input  logic                  clk_pix,
    input  logic                  reset_n,
    input  logic                  a_req,
    input  logic [1:0]            a_op,
    input  logic [OSD_LINE_W-1:0] a_line,
    output logic                  a_gnt,
    input  logic [7:0]            a_dat,
    input  logic                  a_dat_valid,
    output logic                  a_dat_ready,
    input  logic                  b_req,
    input  logic [1:0]            b_op,
    input  logic [OSD_LINE_W-1:0] b_line,
    output logic                  b_gnt,
    input  logic [7:0]            b_dat,
    input  logic                  b_dat_valid,
    output logic                  b_dat_ready,
    output logic                  buf_we,
    output logic [OSD_ADDR_W-1:0] buf_addr,
    output logic [7:0]            buf_wdata,
    output logic                  osd_enable,
    output logic                  busy
);

    osd_state_e            r_state,    w_state_nxt;
    osd_port_e             r_owner,    w_owner_nxt;
    logic [OSD_LINE_W-1:0] r_cur_line, w_line_nxt;
    logic [OSD_BYTE_W-1:0] r_bcnt,     w_bcnt_nxt;
    logic                  w_we_nxt;
    logic [OSD_ADDR_W-1:0] w_addr_nxt;
    logic [7:0]            w_wdata_nxt;
    logic                  w_en_nxt;
    logic                  w_gnt_a_nxt, w_gnt_b_nxt;
    logic                  w_advance;

    osd_port_e             w_winner;
    logic                  w_any_req;
    osd_op_e               w_sel_op;
    logic [OSD_LINE_W-1:0] w_sel_line;
    logic                  w_own_req, w_own_valid;
    logic [7:0]            w_own_dat;
    logic                  w_last_byte;

    rr_arb2 u_arb (
        .clk     (clk_pix),
        .rst_n   (reset_n),
        .req_a   (a_req),
        .req_b   (b_req),
        .advance (w_advance),
        .winner  (w_winner),
        .valid   (w_any_req)
    );

    assign w_sel_op    = (w_winner == PORT_B) ? osd_op_e'(b_op) : osd_op_e'(a_op);
    assign w_sel_line  = (w_winner == PORT_B) ? b_line : a_line;
    assign w_own_req   = (r_owner == PORT_B) ? b_req       : a_req;
    assign w_own_valid = (r_owner == PORT_B) ? b_dat_valid : a_dat_valid;
    assign w_own_dat   = (r_owner == PORT_B) ? b_dat       : a_dat;
    assign w_last_byte = (r_bcnt == {OSD_BYTE_W{1'b1}});

    // Ready depends only on state and owner, never on the valid inputs.
    assign a_dat_ready = (r_state == ST_WRITE) && (r_owner == PORT_A);
    assign b_dat_ready = (r_state == ST_WRITE) && (r_owner == PORT_B);
    assign busy        = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_line_nxt  = r_cur_line;
        w_bcnt_nxt  = r_bcnt;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = buf_addr;
        w_wdata_nxt = buf_wdata;
        w_en_nxt    = osd_enable;
        w_gnt_a_nxt = 1'b0;
        w_gnt_b_nxt = 1'b0;
        w_advance   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_advance   = 1'b1;
                    w_owner_nxt = w_winner;
                    w_line_nxt  = w_sel_line;
                    w_bcnt_nxt  = '0;
                    w_gnt_a_nxt = (w_winner == PORT_A);
                    w_gnt_b_nxt = (w_winner == PORT_B);
                    case (w_sel_op)
                        OP_WRITE:   w_state_nxt = ST_WRITE;
                        OP_CLEAR:   w_state_nxt = ST_CLEAR;
                        OP_ENABLE:  w_en_nxt    = 1'b1;
                        OP_DISABLE: w_en_nxt    = 1'b0;
                        default:    w_state_nxt = ST_IDLE;
                    endcase
                end
            end

            ST_WRITE: begin
                // A dropped request aborts; the byte offered on that same
                // cycle is discarded, earlier bytes stay written.
                if (!w_own_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_own_valid) begin
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = {r_cur_line, r_bcnt};
                    w_wdata_nxt = w_own_dat;
                    w_bcnt_nxt  = r_bcnt + OSD_BYTE_W'(1);
                    if (w_last_byte) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            ST_CLEAR: begin
                w_we_nxt    = 1'b1;
                w_addr_nxt  = {r_cur_line, r_bcnt};
                w_wdata_nxt = CLEAR_VALUE;
                w_bcnt_nxt  = r_bcnt + OSD_BYTE_W'(1);
                if (w_last_byte) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_owner    <= PORT_A;
            r_cur_line <= '0;
            r_bcnt     <= '0;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_wdata  <= '0;
            osd_enable <= RESET_ENABLE;
            a_gnt      <= 1'b0;
            b_gnt      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_cur_line <= w_line_nxt;
            r_bcnt     <= w_bcnt_nxt;
            buf_we     <= w_we_nxt;
            buf_addr   <= w_addr_nxt;
            buf_wdata  <= w_wdata_nxt;
            osd_enable <= w_en_nxt;
            a_gnt      <= w_gnt_a_nxt;
            b_gnt      <= w_gnt_b_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_osd_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_osd_cmd_arbiter
//  Description : Self-checking bench for osd_cmd_arbiter: reset values, an
//                arbitration vector table, directed multi-cycle sequences and
//                a randomized command stream against a transaction-level
//                model of the buffer contents, enable flag and grant order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_osd_cmd_arbiter;
    import osd_pkg::*;

    localparam logic RST_EN = 1'b0;

    logic        clk_pix = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_req = 0, b_req = 0;
    logic [1:0]  a_op = 0, b_op = 0;
    logic [2:0]  a_line = 0, b_line = 0;
    logic        a_gnt, b_gnt;
    logic [7:0]  a_dat = 0, b_dat = 0;
    logic        a_dat_valid = 0, b_dat_valid = 0;
    logic        a_dat_ready, b_dat_ready;
    logic        buf_we;
    logic [10:0] buf_addr;
    logic [7:0]  buf_wdata;
    logic        osd_enable, busy;

    always #5 clk_pix = ~clk_pix;

    osd_cmd_arbiter #(.CLEAR_VALUE(8'h00), .RESET_ENABLE(RST_EN)) dut (
        .clk_pix(clk_pix), .reset_n(reset_n),
        .a_req(a_req), .a_op(a_op), .a_line(a_line), .a_gnt(a_gnt),
        .a_dat(a_dat), .a_dat_valid(a_dat_valid), .a_dat_ready(a_dat_ready),
        .b_req(b_req), .b_op(b_op), .b_line(b_line), .b_gnt(b_gnt),
        .b_dat(b_dat), .b_dat_valid(b_dat_valid), .b_dat_ready(b_dat_ready),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .osd_enable(osd_enable), .busy(busy)
    );

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic       a_req;
        logic [1:0] a_op;
        logic       b_req;
        logic [1:0] b_op;
        logic       exp_a_gnt;
        logic       exp_b_gnt;
        logic       exp_en;
    } vec_t;

    int   n_pass = 0;
    int   n_total = 0;
    wr_t  wlog[$];
    wr_t  wexp[$];
    logic [7:0] dut_mem [0:2047];
    logic [7:0] ref_mem [0:2047];
    bit   model_last = 1'b1;
    logic model_en = RST_EN;
    bit   other_ready_seen, other_gnt_seen, en_moved, own_ready_low;
    vec_t vecs[10];

    // Buffer-side monitor: every strobe seen is logged and shadowed.
    always @(negedge clk_pix) begin
        if (reset_n && buf_we) begin
            wlog.push_back('{addr: buf_addr, data: buf_wdata});
            dut_mem[buf_addr] = buf_wdata;
        end
    end

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic get_gnt(input bit p);
        return p ? b_gnt : a_gnt;
    endfunction

    function automatic logic get_ready(input bit p);
        return p ? b_dat_ready : a_dat_ready;
    endfunction

    task automatic drive_req(input bit p, input logic r, input logic [1:0] op, input logic [2:0] ln);
        if (p) begin b_req = r; b_op = op; b_line = ln; end
        else   begin a_req = r; a_op = op; a_line = ln; end
    endtask

    task automatic drive_dat(input bit p, input logic v, input logic [7:0] d);
        if (p) begin b_dat_valid = v; b_dat = d; end
        else   begin a_dat_valid = v; a_dat = d; end
    endtask

    task automatic reset_dut();
        a_req = 0; b_req = 0; a_dat_valid = 0; b_dat_valid = 0;
        reset_n = 0;
        repeat (3) tick();
        reset_n = 1;
        tick();
        model_last = 1'b1;
        model_en   = RST_EN;
    endtask

    task automatic wait_gnt(input bit p, input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (get_gnt(p) === 1'b1) begin got = 1; break; end
        end
        chk({name, "_gnt"}, 32'(got), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400; i++) begin
            if (busy === 1'b0) break;
            tick();
        end
        chk({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_writes(input string name);
        int mism;
        mism = 0;
        repeat (2) tick();
        chk({name, "_wr_count"}, 32'(wlog.size()), 32'(wexp.size()));
        for (int i = 0; i < wlog.size() && i < wexp.size(); i++)
            if (wlog[i].addr !== wexp[i].addr || wlog[i].data !== wexp[i].data) mism++;
        chk({name, "_wr_mismatches"}, 32'(mism), 32'd0);
        wlog.delete();
        wexp.delete();
    endtask

    task automatic ctrl_cmd(input bit p, input logic [1:0] op, input string name);
        drive_req(p, 1'b1, op, 3'd0);
        wait_gnt(p, name);
        drive_req(p, 1'b0, op, 3'd0);
        model_en   = (op == OP_ENABLE);
        model_last = p;
        chk({name, "_en"}, 32'(osd_enable), 32'(model_en));
    endtask

    task automatic clear_cmd(input bit p, input logic [2:0] ln, input string name);
        drive_req(p, 1'b1, OP_CLEAR, ln);
        wait_gnt(p, name);
        drive_req(p, 1'b0, OP_CLEAR, ln);
        for (int i = 0; i < 256; i++) begin
            wexp.push_back('{addr: {ln, 8'(i)}, data: 8'h00});
            ref_mem[{ln, 8'(i)}] = 8'h00;
        end
        model_last = p;
        wait_idle(name);
    endtask

    // Streams n bytes; the owner is expected to be ready on every cycle of
    // the transfer, so each offered valid byte counts as accepted. With
    // n < 256 the request is dropped afterwards and one more byte (0xEE) is
    // offered on the abort cycle, which must not be written.
    task automatic write_cmd(input bit p, input logic [2:0] ln, input int n, input bit toggle,
                             input int other_start, input logic [1:0] other_op, input string name);
        int acc, cyc;
        logic v, en0;
        logic [7:0] d;
        acc = 0; cyc = 0;
        other_ready_seen = 0; other_gnt_seen = 0; en_moved = 0; own_ready_low = 0;
        drive_req(p, 1'b1, OP_WRITE, ln);
        drive_dat(p, 1'b0, 8'h00);
        wait_gnt(p, name);
        en0 = osd_enable;
        while (acc < n && cyc < 2000) begin
            if (cyc == other_start) drive_req(!p, 1'b1, other_op, 3'd0);
            v = toggle ? ((cyc % 2) == 0) : 1'b1;
            d = 8'($urandom);
            drive_dat(p, v, d);
            if (get_ready(!p) !== 1'b0) other_ready_seen = 1;
            if (get_ready(p) !== 1'b1) own_ready_low = 1;
            if (v) begin
                wexp.push_back('{addr: {ln, 8'(acc)}, data: d});
                ref_mem[{ln, 8'(acc)}] = d;
                acc++;
            end
            tick();
            cyc++;
            if (get_gnt(!p) === 1'b1) other_gnt_seen = 1;
            if (osd_enable !== en0) en_moved = 1;
        end
        drive_req(p, 1'b0, OP_WRITE, ln);
        chk({name, "_accepts"}, 32'(acc), 32'(n));
        chk({name, "_own_ready"}, 32'(own_ready_low), 32'd0);
        if (n < 256) begin
            drive_dat(p, 1'b1, 8'hEE);
            tick();
        end
        drive_dat(p, 1'b0, 8'h00);
        model_last = p;
    endtask

    initial begin
        int  ng;
        bit  order[3];
        bit  w;
        int  mism;
        logic [1:0] op_a, op_b;

        vecs[0] = '{1'b1, OP_ENABLE,  1'b0, OP_WRITE,   1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, OP_ENABLE,  1'b0, OP_WRITE,   1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, OP_DISABLE, 1'b1, OP_ENABLE,  1'b0, 1'b1, 1'b1};
        vecs[3] = '{1'b1, OP_DISABLE, 1'b1, OP_ENABLE,  1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, OP_ENABLE,  1'b0, OP_WRITE,   1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, OP_DISABLE, 1'b1, OP_DISABLE, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, OP_WRITE,   1'b1, OP_ENABLE,  1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b1, OP_ENABLE,  1'b1, OP_DISABLE, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{1'b1, OP_DISABLE, 1'b1, OP_ENABLE,  1'b0, 1'b1, 1'b1};
        vecs[9] = '{1'b0, OP_WRITE,   1'b0, OP_WRITE,   1'b0, 1'b0, 1'b1};

        // ---------------- reset values ----------------
        reset_n = 0;
        repeat (2) tick();
        chk("rst_busy",    32'(busy),        32'd0);
        chk("rst_we",      32'(buf_we),      32'd0);
        chk("rst_addr",    32'(buf_addr),    32'd0);
        chk("rst_wdata",   32'(buf_wdata),   32'd0);
        chk("rst_en",      32'(osd_enable),  32'(RST_EN));
        chk("rst_gnt",     32'({a_gnt, b_gnt}), 32'd0);
        chk("rst_ready",   32'({a_dat_ready, b_dat_ready}), 32'd0);
        reset_n = 1;
        tick();

        // ---------------- arbitration vector table ----------------
        for (int i = 0; i < 10; i++) begin
            a_req = vecs[i].a_req; a_op = vecs[i].a_op;
            b_req = vecs[i].b_req; b_op = vecs[i].b_op;
            tick();
            chk($sformatf("vec%0d_a_gnt", i), 32'(a_gnt), 32'(vecs[i].exp_a_gnt));
            chk($sformatf("vec%0d_b_gnt", i), 32'(b_gnt), 32'(vecs[i].exp_b_gnt));
            chk($sformatf("vec%0d_en", i),    32'(osd_enable), 32'(vecs[i].exp_en));
            chk($sformatf("vec%0d_busy", i),  32'(busy), 32'd0);
        end
        a_req = 0; b_req = 0;
        tick();
        wlog.delete(); wexp.delete();

        // ---------------- full-rate WRITE, line 3 ----------------
        write_cmd(1'b0, 3'd3, 256, 1'b0, -1, OP_WRITE, "wr_full");
        chk("wr_full_busy_after", 32'(busy), 32'd0);
        chk("wr_full_trailing_we", 32'(buf_we), 32'd1);
        chk("wr_full_b_ready", 32'(other_ready_seen), 32'd0);
        check_writes("wr_full");

        // ---------------- tied CLEARs: grant order A, B, A ----------------
        reset_dut();
        wlog.delete(); wexp.delete();
        drive_req(1'b0, 1'b1, OP_CLEAR, 3'd2);
        drive_req(1'b1, 1'b1, OP_CLEAR, 3'd5);
        ng = 0;
        for (int i = 0; i < 1200 && ng < 3; i++) begin
            tick();
            if (a_gnt === 1'b1) begin order[ng] = 1'b0; ng++; end
            else if (b_gnt === 1'b1) begin order[ng] = 1'b1; ng++; end
        end
        drive_req(1'b0, 1'b0, OP_CLEAR, 3'd2);
        drive_req(1'b1, 1'b0, OP_CLEAR, 3'd5);
        chk("tie_clr_grants", 32'(ng), 32'd3);
        chk("tie_clr_order0", 32'(order[0]), 32'd0);
        chk("tie_clr_order1", 32'(order[1]), 32'd1);
        chk("tie_clr_order2", 32'(order[2]), 32'd0);
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 256; i++)
                wexp.push_back('{addr: {(k == 1) ? 3'd5 : 3'd2, 8'(i)}, data: 8'h00});
        wait_idle("tie_clr");
        check_writes("tie_clr");
        model_last = 1'b0;

        // ---------------- WRITE line 7, toggled valid, abort after 10 ----------------
        write_cmd(1'b0, 3'd7, 10, 1'b1, -1, OP_WRITE, "wr_abort");
        chk("wr_abort_busy", 32'(busy), 32'd0);
        check_writes("wr_abort");

        // ---------------- B WRITE while A asks for DISABLE ----------------
        ctrl_cmd(1'b1, OP_ENABLE, "b_en");
        write_cmd(1'b1, 3'd1, 256, 1'b0, 5, OP_DISABLE, "b_wr");
        chk("b_wr_a_gnt_during", 32'(other_gnt_seen), 32'd0);
        chk("b_wr_en_stable", 32'(en_moved), 32'd0);
        chk("b_wr_a_ready", 32'(other_ready_seen), 32'd0);
        tick();
        chk("b_wr_a_gnt_after", 32'(a_gnt), 32'd1);
        chk("b_wr_en_after", 32'(osd_enable), 32'd0);
        drive_req(1'b0, 1'b0, OP_DISABLE, 3'd0);
        model_en = 1'b0; model_last = 1'b0;
        check_writes("b_wr");

        // ---------------- reset in the middle of a CLEAR ----------------
        ctrl_cmd(1'b0, OP_ENABLE, "pre_rst");
        drive_req(1'b0, 1'b1, OP_CLEAR, 3'd4);
        wait_gnt(1'b0, "mid_clr");
        drive_req(1'b0, 1'b0, OP_CLEAR, 3'd4);
        repeat (100) tick();
        chk("mid_clr_we", 32'(buf_we), 32'd1);
        chk("mid_clr_addr", 32'(buf_addr), 32'h463);
        #2 reset_n = 0;
        #1;
        chk("mid_rst_we", 32'(buf_we), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_en", 32'(osd_enable), 32'(RST_EN));
        chk("mid_rst_addr", 32'(buf_addr), 32'd0);
        repeat (2) tick();
        reset_n = 1;
        tick();
        drive_req(1'b0, 1'b1, OP_ENABLE, 3'd0);
        drive_req(1'b1, 1'b1, OP_DISABLE, 3'd0);
        tick();
        chk("post_rst_tie_a", 32'({a_gnt, b_gnt}), 32'b10);
        drive_req(1'b0, 1'b0, OP_ENABLE, 3'd0);
        tick();
        chk("post_rst_tie_b", 32'({a_gnt, b_gnt}), 32'b01);
        drive_req(1'b1, 1'b0, OP_DISABLE, 3'd0);
        chk("post_rst_en", 32'(osd_enable), 32'd0);
        model_last = 1'b1; model_en = 1'b0;

        // ---------------- randomized command stream ----------------
        reset_dut();
        for (int i = 0; i < 2048; i++) begin dut_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        wlog.delete(); wexp.delete();
        for (int it = 0; it < 16; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    write_cmd(1'($urandom), 3'($urandom),
                              ($urandom_range(0, 3) == 0) ? 256 : int'($urandom_range(1, 30)),
                              1'($urandom), -1, OP_WRITE, "rnd_wr");
                    chk("rnd_wr_en", 32'(osd_enable), 32'(model_en));
                end
                1: clear_cmd(1'($urandom), 3'($urandom), "rnd_clr");
                2: ctrl_cmd(1'($urandom), 2'($urandom_range(2, 3)), "rnd_ctl");
                default: begin
                    op_a = 2'($urandom_range(2, 3));
                    op_b = 2'($urandom_range(2, 3));
                    drive_req(1'b0, 1'b1, op_a, 3'd0);
                    drive_req(1'b1, 1'b1, op_b, 3'd0);
                    w = !model_last;
                    tick();
                    chk("rnd_tie_first", 32'({a_gnt, b_gnt}), w ? 32'b01 : 32'b10);
                    drive_req(w, 1'b0, OP_ENABLE, 3'd0);
                    tick();
                    chk("rnd_tie_second", 32'({a_gnt, b_gnt}), w ? 32'b10 : 32'b01);
                    drive_req(!w, 1'b0, OP_ENABLE, 3'd0);
                    model_last = !w;
                    model_en   = ((w ? op_a : op_b) == OP_ENABLE);
                    chk("rnd_tie_en", 32'(osd_enable), 32'(model_en));
                end
            endcase
        end
        check_writes("rnd");
        mism = 0;
        for (int i = 0; i < 2048; i++) if (dut_mem[i] !== ref_mem[i]) mism++;
        chk("rnd_mem_image", 32'(mism), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/osd_cmd_arbiter.md
# osd_cmd_arbiter

Command scheduler for the OSD character/pixel buffer. It shares the buffer's single write port and the OSD enable flag between two requesters: port A is the io-controller SPI command decoder, port B is a core-local message source such as a status or error line. It arbitrates round-robin and sequences each granted command to completion, including self-generated line clears. It sits in the `clk_pix` domain between the requesters and the 2048x8 OSD buffer write port.

## Interface
Parameters:
- `CLEAR_VALUE`, default `8'h00`: byte written by the CLEAR op.
- `RESET_ENABLE`, default `1'b0`: value of `osd_enable` after reset.

Ports:
- `clk_pix` in 1: pixel clock; the only clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `a_req`, `b_req` in 1: command request. Held high with op/line stable until grant; for WRITE, held for the whole transfer.
- `a_op`, `b_op` in 2: 0 WRITE, 1 CLEAR, 2 ENABLE, 3 DISABLE.
- `a_line`, `b_line` in 3: target OSD line (256-byte row).
- `a_gnt`, `b_gnt` out 1: one-cycle grant pulse.
- `a_dat`, `b_dat` in 8: WRITE payload byte.
- `a_dat_valid`, `b_dat_valid` in 1: payload valid.
- `a_dat_ready`, `b_dat_ready` out 1: payload accepted when valid && ready.
- `buf_we` out 1: buffer write strobe (registered).
- `buf_addr` out 11: {line, byte index} (registered).
- `buf_wdata` out 8: write data (registered).
- `osd_enable` out 1: OSD display enable.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, WRITE, CLEAR.
- IDLE:
  - If any req is high, select a winner, latch its op/line into `cur_op`/`cur_line`, pulse its gnt, and set `last` to the winner.
  - Round-robin: with both requesting, the port not equal to `last` wins; a single requester always wins. Reset value of `last` is B, so A wins the first tie.
  - ENABLE/DISABLE: `osd_enable` is set to 1/0 on the grant edge; state stays IDLE. The next grant is possible the following cycle.
  - WRITE: go to WRITE with `bcnt` = 0.
  - CLEAR: go to CLEAR with `bcnt` = 0.
- WRITE:
  - The owner's `dat_ready` = 1; the other port's is 0.
  - Each accepted byte produces a write at `{cur_line, bcnt}` with the byte value, then `bcnt` increments (8-bit).
  - After the accept at `bcnt` = 255, return to IDLE.
  - If the owner's req drops before 256 accepts: abort to IDLE on that edge. The byte on that same cycle is not accepted, and written bytes are kept.
- CLEAR:
  - Writes `CLEAR_VALUE` at `{cur_line, bcnt}` every cycle, `bcnt` 0..255, then IDLE.
  - Uninterruptible; req is ignored during CLEAR.
- The non-owner's req is ignored until IDLE; it is not lost, since it is re-evaluated in IDLE.
- `dat_ready` is combinational from state/owner only and never depends on `dat_valid`.
- Reset (async, any state):
  - State → IDLE; `last` → B; `bcnt` → 0.
  - All gnt, ready, `buf_we` and `busy` → 0; `buf_addr` → 0; `buf_wdata` → 0.
  - `osd_enable` → `RESET_ENABLE`.
  - A transfer in progress is discarded.

## Timing
- Grant: the req seen high in IDLE at edge N gives gnt high during cycle N+1 (registered).
  - WRITE/CLEAR: `busy` is high from that cycle onward.
  - ENABLE/DISABLE: `osd_enable` changes at edge N.
- WRITE latency: a byte accepted at edge K gives `buf_we` = 1 with its addr/data during cycle K+1.
  - Full-rate transfer: 256 cycles plus 1 trailing `buf_we` cycle.
- CLEAR: 256 consecutive `buf_we` cycles, the first one cycle after grant.
- IDLE re-arbitrates on the first cycle back in IDLE. The minimum gap between two WRITE/CLEAR commands is 1 IDLE cycle.
- `buf_we` is never high in IDLE except for the trailing write of the last accepted WRITE byte.

## Structure
- Shared package `osd_pkg`:
  - op encodings `OP_WRITE`/`OP_CLEAR`/`OP_ENABLE`/`OP_DISABLE`.
  - `OSD_LINE_BYTES` = 256, `OSD_LINES` = 8.
  - buffer address width 11.
- One natural sub-module: `rr_arb2`, a 2-way round-robin arbiter with a `last` pointer and an `advance` input.
- Everything else lives in a single FSM.

## Test plan
- Reset then `a_req` ENABLE → `a_gnt` pulse 1 cycle after; `osd_enable` = 1; `busy` stays 0.
- `a_req` WRITE line 3, 256 bytes 0x00..0xFF, `dat_valid` always 1 → 256 `buf_we` with `buf_addr` 0x300..0x3FF and data equal to `addr[7:0]`; `busy` falls after byte 255; `b_dat_ready` never 1.
- `a_req` and `b_req` both CLEAR, same cycle, repeated 3 times → grant order A, B, A; each clear gives 256 writes of 0x00.
- WRITE line 7 with `dat_valid` toggled every other cycle, req dropped after 10 accepts → exactly 10 writes at 0x700..0x709, then return to IDLE.
- B WRITE in progress while A requests DISABLE → A is granted only after B's 256th byte; `osd_enable` is unchanged during B's transfer.
- `reset_n` asserted mid-CLEAR at `bcnt` = 100 → `buf_we` goes 0 immediately and `osd_enable` = `RESET_ENABLE`. After release, tied requests go to A first.
